y86_mem_arbiter: RTL

- Shares the single y86 memory bus between two requesters: port 0 (CPU fetch/load/store) and port 1 (DMA/debug loader).
- Arbitrates, sequences each transfer onto the memory bus, waits a fixed read latency, and returns read data to the owner.
- Port 0 has default priority; a starvation counter guarantees port 1 progress.

---
 rtl/y86_mem_arbiter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/y86_mem_arbiter.sv
// Two-port arbiter for the shared y86 memory bus.
// Port 0 (CPU) has default priority; port 1 (DMA/debug loader) is forced
// through once port 0 has won STARVE_MAX consecutive contested decisions.
// All outputs derive from registered state; nothing is combinational from inputs.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no transfer in flight; arbitrate any pending request
// ACCESS | latched transfer driven onto the bus for one cycle, gnt pulsed
// WAIT   | read in flight; count down until mem_rdata is valid, then capture
module y86_mem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,

    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,

    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [DW-1:0] mem_rdata,

    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    // Read latency fits in 3 bits (1..7); starve limit fits in 4 bits (1..15).
    localparam logic [2:0] CNT_LOAD   = 3'(RD_LAT - 1);
    localparam logic [3:0] STARVE_TOP = 4'(STARVE_MAX);

    state_t          state;
    state_t          state_nxt;

    logic            owner;
    logic            we_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [2:0]      cnt;
    logic [3:0]      starve;

    logic [DW-1:0]   rdata0_q;
    logic [DW-1:0]   rdata1_q;
    logic            rvalid0_q;
    logic            rvalid1_q;

    logic            any_req;
    logic            pick1;
    logic            decide;
    logic            capture;

    // Winner selection: port 1 only when alone or when port 0 has starved it.
    always_comb begin
        any_req = m0_req | m1_req;
        pick1   = m1_req & (~m0_req | (starve == STARVE_TOP));
        decide  = (state == S_IDLE) & any_req;
        capture = (state == S_WAIT) & (cnt == 3'd0);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and bus/grant outputs, all decoded from registered state.
    always_comb begin
        state_nxt = state;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        m0_gnt    = 1'b0;
        m1_gnt    = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (any_req) begin
                    state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                mem_we    = we_q;
                mem_re    = ~we_q;
                m0_gnt    = ~owner;
                m1_gnt    = owner;
                state_nxt = we_q ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (cnt == 3'd0) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Latch the winning request's transfer at the arbitration decision.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (decide) begin
            owner   <= pick1;
            we_q    <= pick1 ? m1_we    : m0_we;
            addr_q  <= pick1 ? m1_addr  : m0_addr;
            wdata_q <= pick1 ? m1_wdata : m0_wdata;
        end
    end

    // Read latency down-counter: loaded on a read ACCESS, terminal count ends WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 3'd0;
        end else if ((state == S_ACCESS) && !we_q) begin
            cnt <= CNT_LOAD;
        end else if ((state == S_WAIT) && (cnt != 3'd0)) begin
            cnt <= cnt - 3'd1;
        end
    end

    // Starvation counter: counts contested port-0 wins, saturating at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve <= 4'd0;
        end else if (!m1_req) begin
            starve <= 4'd0;
        end else if (decide) begin
            if (pick1) begin
                starve <= 4'd0;
            end else if (starve != STARVE_TOP) begin
                starve <= starve + 4'd1;
            end
        end
    end

    // Read data capture and the one-cycle rvalid that follows it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            rvalid0_q <= capture & ~owner;
            rvalid1_q <= capture & owner;
            if (capture && !owner) begin
                rdata0_q <= mem_rdata;
            end
            if (capture && owner) begin
                rdata1_q <= mem_rdata;
            end
        end
    end

    assign m0_rvalid = rvalid0_q;
    assign m1_rvalid = rvalid1_q;
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;

endmodule
